// File: rtl/multiplexed_deinterleaver.sv
// Receive-side inverse of the 8-column block interleaver.
// Buffers one column-ordered frame, then streams it out in row-major order.
module multiplexed_deinterleaver #(
    parameter int DATA_W  = 8,
    parameter int COLS    = 8,
    parameter int MAX_LEN = 2712,
    parameter int LEN_W   = 12
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              data_valid,
    output logic              data_ready,
    input  logic [LEN_W-1:0]  length,
    output logic [DATA_W-1:0] data_out,
    output logic              data_out_valid,
    input  logic              data_out_ready,
    output logic              frame_last,
    output logic              frame_err
);

    localparam int COL_SHIFT = $clog2(COLS);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DRAIN
    } state_t;

    state_t state;

    logic [DATA_W-1:0] mem [MAX_LEN];

    logic [LEN_W-1:0] len;
    logic [LEN_W-1:0] rows;
    logic [LEN_W-1:0] row;
    logic [LEN_W-1:0] col;
    logic [LEN_W-1:0] addr;
    logic [LEN_W-1:0] in_cnt;
    logic [LEN_W-1:0] rd_ptr;
    logic             rd_done;

    logic             accept;
    logic             length_ok;
    logic             wr_en;
    logic [LEN_W-1:0] wr_addr;
    logic [LEN_W-1:0] next_col;
    logic [LEN_W-1:0] length_rows;
    logic             out_take;
    logic             load;

    assign accept      = data_valid && data_ready;
    assign length_ok   = (length >= LEN_W'(COLS)) &&
                         ((length & LEN_W'(COLS - 1)) == '0) &&
                         (length <= LEN_W'(MAX_LEN));
    assign length_rows = length >> COL_SHIFT;
    assign wr_en       = accept && (((state == IDLE) && length_ok) || (state == FILL));
    assign wr_addr     = (state == IDLE) ? '0 : addr;
    assign next_col    = col + LEN_W'(1);
    assign out_take    = data_out_valid && data_out_ready;
    // The output register can be refilled whenever it is empty or being consumed.
    assign load        = (state == DRAIN) && !rd_done && (!data_out_valid || data_out_ready);

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            len            <= '0;
            rows           <= '0;
            row            <= '0;
            col            <= '0;
            addr           <= '0;
            in_cnt         <= '0;
            rd_ptr         <= '0;
            rd_done        <= 1'b0;
            data_out       <= '0;
            data_out_valid <= 1'b0;
            frame_last     <= 1'b0;
            frame_err      <= 1'b0;
            data_ready     <= 1'b0;
        end else begin
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    data_ready <= 1'b1;
                    if (accept) begin
                        if (length_ok) begin
                            len    <= length;
                            rows   <= length_rows;
                            in_cnt <= LEN_W'(1);
                            // Byte 0 went to address 0; advance as if it were any other byte.
                            if (length_rows == LEN_W'(1)) begin
                                row  <= '0;
                                col  <= LEN_W'(1);
                                addr <= LEN_W'(1);
                            end else begin
                                row  <= LEN_W'(1);
                                col  <= '0;
                                addr <= LEN_W'(COLS);
                            end
                            state <= FILL;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end

                FILL: begin
                    if (accept) begin
                        if (in_cnt == len - LEN_W'(1)) begin
                            state      <= DRAIN;
                            data_ready <= 1'b0;
                            in_cnt     <= '0;
                            row        <= '0;
                            col        <= '0;
                            addr       <= '0;
                            rd_ptr     <= '0;
                            rd_done    <= 1'b0;
                        end else begin
                            in_cnt <= in_cnt + LEN_W'(1);
                            if (row == rows - LEN_W'(1)) begin
                                row  <= '0;
                                col  <= next_col;
                                addr <= next_col;
                            end else begin
                                row  <= row + LEN_W'(1);
                                addr <= addr + LEN_W'(COLS);
                            end
                        end
                    end
                end

                DRAIN: begin
                    if (out_take && frame_last) begin
                        state          <= IDLE;
                        data_out_valid <= 1'b0;
                        frame_last     <= 1'b0;
                        data_ready     <= 1'b1;
                    end else if (load) begin
                        data_out       <= mem[rd_ptr];
                        data_out_valid <= 1'b1;
                        frame_last     <= (rd_ptr == len - LEN_W'(1));
                        // Park the pointer on the last address instead of running past it.
                        if (rd_ptr == len - LEN_W'(1)) begin
                            rd_done <= 1'b1;
                        end else begin
                            rd_ptr <= rd_ptr + LEN_W'(1);
                        end
                    end else if (out_take) begin
                        data_out_valid <= 1'b0;
                        frame_last     <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multiplexed_deinterleaver.sv
// Directed bench for multiplexed_deinterleaver: frames are interleaved by a
// column-order reference and the de-interleaved stream is checked byte by byte.
module tb_multiplexed_deinterleaver;

    localparam int DATA_W  = 8;
    localparam int COLS    = 8;
    localparam int MAX_LEN = 2712;
    localparam int LEN_W   = 12;

    logic              clk = 1'b0;
    logic              reset;
    logic [DATA_W-1:0] data_in;
    logic              data_valid;
    logic              data_ready;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] data_out;
    logic              data_out_valid;
    logic              data_out_ready;
    logic              frame_last;
    logic              frame_err;

    int vectors     = 0;
    int miscompares = 0;

    logic [DATA_W-1:0] payload [MAX_LEN];

    multiplexed_deinterleaver #(
        .DATA_W (DATA_W),
        .COLS   (COLS),
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .data_in       (data_in),
        .data_valid    (data_valid),
        .data_ready    (data_ready),
        .length        (length),
        .data_out      (data_out),
        .data_out_valid(data_out_valid),
        .data_out_ready(data_out_ready),
        .frame_last    (frame_last),
        .frame_err     (frame_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_ready"},     data_ready,     0);
        checkOutput({tag, "_valid"},     data_out_valid, 0);
        checkOutput({tag, "_data"},      data_out,       0);
        checkOutput({tag, "_last"},      frame_last,     0);
        checkOutput({tag, "_err"},       frame_err,      0);
    endtask

    // Sends the first 'count' bytes of payload[0..len-1] in transmit column order.
    task automatic applyStimulus(input int len, input int count);
        int rows;
        rows = len / COLS;
        for (int i = 0; i < count; i++) begin
            int budget;
            budget     = 0;
            data_valid = 1'b1;
            data_in    = payload[(i % rows) * COLS + i / rows];
            length     = (i == 0) ? LEN_W'(len) : '1;
            while (!data_ready && budget < 100) begin
                tick();
                budget++;
            end
            checkOutput("fill_ready", data_ready, 1);
            tick();
        end
        data_valid = 1'b0;
        if (count == len) begin
            checkOutput("ready_drop", data_ready, 0);
            checkOutput("no_early_valid", data_out_valid, 0);
        end
    endtask

    // Drains one frame; junk is offered on the input side to show it is ignored.
    task automatic collectFrame(input int len, input bit stall);
        int k;
        int cyc;
        int first_cyc;
        k          = 0;
        cyc        = 0;
        first_cyc  = -1;
        data_valid = 1'b1;
        data_in    = 8'h5A;
        length     = LEN_W'(16);
        while (k < len && cyc < 4 * len + 20) begin
            data_out_ready = stall ? ((cyc % 3) == 0) : 1'b1;
            if (first_cyc >= 0) begin
                checkOutput("valid_hold", data_out_valid, 1);
            end
            if (data_out_valid) begin
                if (first_cyc < 0) first_cyc = cyc;
                checkOutput("drain_ready_low", data_ready, 0);
                checkOutput("data_out", data_out, payload[k]);
                checkOutput("frame_last", frame_last, (k == len - 1));
                if (data_out_ready) begin
                    k++;
                    if (k == len) data_valid = 1'b0;
                end
            end
            tick();
            cyc++;
        end
        data_valid = 1'b0;
        checkOutput("frame_done", k, len);
        if (!stall) checkOutput("first_latency", first_cyc, 1);
        checkOutput("valid_drop", data_out_valid, 0);
        checkOutput("ready_back", data_ready, 1);
        checkOutput("no_err", frame_err, 0);
        data_out_ready = 1'b0;
    endtask

    task automatic badLength(input int len);
        data_valid = 1'b1;
        data_in    = 8'hEE;
        length     = LEN_W'(len);
        checkOutput("bad_ready", data_ready, 1);
        tick();
        data_valid = 1'b0;
        checkOutput("err_pulse", frame_err, 1);
        checkOutput("err_no_valid", data_out_valid, 0);
        checkOutput("err_idle_ready", data_ready, 1);
        tick();
        checkOutput("err_clear", frame_err, 0);
        checkOutput("err_still_no_valid", data_out_valid, 0);
        checkOutput("err_still_ready", data_ready, 1);
    endtask

    initial begin
        reset          = 1'b1;
        data_valid     = 1'b0;
        data_in        = '0;
        length         = '0;
        data_out_ready = 1'b0;
        tick();
        tick();
        tick();
        checkResetState("reset");
        reset = 1'b0;
        tick();
        checkOutput("ready_after_reset", data_ready, 1);

        $display("[TB] L=16 frame, ready held high");
        for (int k = 0; k < 16; k++) payload[k] = DATA_W'(k);
        applyStimulus(16, 16);
        collectFrame(16, 1'b0);

        $display("[TB] L=24 then back-to-back L=8");
        for (int k = 0; k < 24; k++) payload[k] = DATA_W'(k);
        applyStimulus(24, 24);
        collectFrame(24, 1'b0);
        for (int k = 0; k < 8; k++) payload[k] = DATA_W'(8'hC0 + k);
        applyStimulus(8, 8);
        collectFrame(8, 1'b0);

        $display("[TB] L=16 with output backpressure");
        for (int k = 0; k < 16; k++) payload[k] = DATA_W'(8'hA0 + k);
        applyStimulus(16, 16);
        collectFrame(16, 1'b1);

        $display("[TB] bad lengths");
        badLength(0);
        badLength(12);
        badLength(2720);
        for (int k = 0; k < 16; k++) payload[k] = DATA_W'(8'h30 + 3 * k);
        applyStimulus(16, 16);
        collectFrame(16, 1'b0);

        $display("[TB] maximum frame L=2712");
        for (int k = 0; k < MAX_LEN; k++) payload[k] = DATA_W'($urandom_range(0, 255));
        applyStimulus(MAX_LEN, MAX_LEN);
        collectFrame(MAX_LEN, 1'b0);

        $display("[TB] reset during fill");
        for (int k = 0; k < 16; k++) payload[k] = DATA_W'(8'h70 + k);
        applyStimulus(16, 5);
        reset = 1'b1;
        tick();
        checkResetState("midfill_reset");
        reset = 1'b0;
        tick();
        checkOutput("ready_after_midfill", data_ready, 1);
        for (int k = 0; k < 16; k++) payload[k] = DATA_W'(8'hF0 - k);
        applyStimulus(16, 16);
        collectFrame(16, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
